// File: rtl/anomaly_monitor_mc.sv
// anomaly_monitor_mc: per-channel price/volume anomaly detection with alert FSMs and a round-robin event output
module anomaly_monitor_mc #(
  parameter int NCH = 4,
  parameter int PW = 12,
  parameter int HIST_LOG2 = 3,
  parameter int COOLDOWN = 16,
  localparam int CW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [CW-1:0] in_ch,
  input  logic [1:0]    in_type,
  input  logic [PW-1:0] in_data,
  input  logic [NCH-1:0] ch_enable,
  input  logic [PW-1:0] spike_thresh,
  input  logic [PW-1:0] flash_thresh,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [CW-1:0] evt_ch,
  output logic [2:0]    evt_type,
  output logic [NCH-1:0] alert_pending,
  output logic [7:0]    overrun_cnt
);
  localparam int DEPTH = 1 << HIST_LOG2;
  localparam int SW = PW + HIST_LOG2;
  localparam int TW = $clog2(COOLDOWN + 1);
  localparam logic [HIST_LOG2:0] FULL = (HIST_LOG2 + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ALERT, COOL} state_t;
  logic [NCH-1:0][DEPTH-1:0][PW-1:0] ring_p, ring_v;
  logic [NCH-1:0][SW-1:0] sum_p, sum_v;
  logic [NCH-1:0][HIST_LOG2-1:0] ptr_p, ptr_v;
  logic [NCH-1:0][HIST_LOG2:0] warm_p, warm_v;
  logic [NCH-1:0][PW-1:0] last_p;
  state_t [NCH-1:0] st, st_n;
  logic [NCH-1:0][2:0] typ, typ_n;
  logic [NCH-1:0][TW-1:0] cnt, cnt_n;
  logic [NCH-1:0] pend, hit;
  logic [CW-1:0] rr, gnt, idx;
  logic found, take, sup;
  logic is_p, is_v, wp, wv, flash, spike, surge, dry, det;
  logic [PW-1:0] avg_p, avg_v, lp, diff;
  logic [2:0] det_type;

  // detection always sees the statistics as they were before this sample
  always_comb begin
    is_p = in_valid && ch_enable[in_ch] && in_type == 2'd0;
    is_v = in_valid && ch_enable[in_ch] && in_type == 2'd1;
    wp = warm_p[in_ch] == FULL;
    wv = warm_v[in_ch] == FULL;
    avg_p = PW'(sum_p[in_ch] >> HIST_LOG2);
    avg_v = PW'(sum_v[in_ch] >> HIST_LOG2);
    lp = last_p[in_ch];
    diff = in_data > lp ? in_data - lp : lp - in_data;
    flash = is_p && wp && avg_p > in_data && (avg_p - in_data) > flash_thresh;
    spike = is_p && wp && diff > spike_thresh;
    surge = is_v && wv && {1'b0, in_data} > {avg_v, 1'b0};
    dry = is_v && wv && in_data < (avg_v >> 2);
    det = flash || surge || dry || spike;
    det_type = flash ? 3'd7 : surge ? 3'd2 : dry ? 3'd1 : 3'd0;
    hit = det ? NCH'(1) << in_ch : '0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ring_p <= '0;
      ring_v <= '0;
      sum_p <= '0;
      sum_v <= '0;
      ptr_p <= '0;
      ptr_v <= '0;
      warm_p <= '0;
      warm_v <= '0;
      last_p <= '0;
    end else if (in_valid && in_type == 2'd0) begin
      ring_p[in_ch][ptr_p[in_ch]] <= in_data;
      sum_p[in_ch] <= sum_p[in_ch] - SW'(ring_p[in_ch][ptr_p[in_ch]]) + SW'(in_data);
      ptr_p[in_ch] <= ptr_p[in_ch] + HIST_LOG2'(1);
      warm_p[in_ch] <= wp ? warm_p[in_ch] : warm_p[in_ch] + (HIST_LOG2 + 1)'(1);
      last_p[in_ch] <= in_data;
    end else if (in_valid && in_type == 2'd1) begin
      ring_v[in_ch][ptr_v[in_ch]] <= in_data;
      sum_v[in_ch] <= sum_v[in_ch] - SW'(ring_v[in_ch][ptr_v[in_ch]]) + SW'(in_data);
      ptr_v[in_ch] <= ptr_v[in_ch] + HIST_LOG2'(1);
      warm_v[in_ch] <= wv ? warm_v[in_ch] : warm_v[in_ch] + (HIST_LOG2 + 1)'(1);
    end

  always_comb begin
    for (int i = 0; i < NCH; i++) pend[i] = st[i] == ALERT;
    gnt = rr;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = rr + CW'(k);
      if (!found && pend[idx]) begin
        gnt = idx;
        found = 1'b1;
      end
    end
    take = found && (!evt_valid || evt_ready);
  end

  // a channel whose event is loaded this cycle judges a new detection as if already cooling
  always_comb begin
    st_n = st;
    typ_n = typ;
    cnt_n = cnt;
    sup = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (st[i] == ALERT && take && gnt == CW'(i)) begin
        st_n[i] = COOL;
        cnt_n[i] = TW'(COOLDOWN);
      end else if (st[i] == COOL) begin
        cnt_n[i] = cnt[i] - TW'(1);
        if (cnt[i] == TW'(1)) st_n[i] = IDLE;
      end
      if (hit[i]) begin
        if (st[i] == IDLE) begin
          st_n[i] = ALERT;
          typ_n[i] = det_type;
        end else if (st_n[i] == COOL || st[i] == COOL) begin
          if (det_type == 3'd7 && typ[i] != 3'd7) begin
            st_n[i] = ALERT;
            typ_n[i] = 3'd7;
          end else sup = 1'b1;
        end else if (det_type > typ[i]) typ_n[i] = det_type;
        else sup = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      evt_valid <= 1'b0;
      evt_ch <= '0;
      evt_type <= '0;
      rr <= '0;
      for (int i = 0; i < NCH; i++) st[i] <= IDLE;
      typ <= '0;
      cnt <= '0;
      overrun_cnt <= '0;
    end else begin
      evt_valid <= take || (evt_valid && !evt_ready);
      if (take) begin
        evt_ch <= gnt;
        evt_type <= typ[gnt];
        rr <= gnt;
      end
      st <= st_n;
      typ <= typ_n;
      cnt <= cnt_n;
      if (sup && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
    end

  assign alert_pending = pend;
endmodule
